ifu_queued: RTL and testbench

//  Parametrised instruction fetch unit for the MIPS core with a decoupled fetch queue.

---
 rtl/ifu_queued_pkg.sv | 8 +
 rtl/ifu_im.sv | 17 +
 rtl/ifu_queued.sv | 77 +++++++
 tb/tb_ifu_queued.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ifu_queued_pkg.sv
// ifu_queued_pkg: redirect-mode encodings and reset fetch address shared by the fetch unit
package ifu_queued_pkg;
  localparam logic [1:0] IFU_SEL_NORM = 2'd0;
  localparam logic [1:0] IFU_SEL_RELATIVE = 2'd1;
  localparam logic [1:0] IFU_SEL_IRRELATIVE = 2'd2;
  localparam logic [1:0] IFU_SEL_REGISTER = 2'd3;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/ifu_im.sv
// ifu_im: word-addressed instruction memory with combinational read
module ifu_im #(
  parameter int IM_AW = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IM_AW-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IM_AW-1:0] raddr,
  output logic [31:0]      rdata
);
  logic [31:0] im [2**IM_AW];
  // optional write port for in-system loading
  always_ff @(posedge clk)
    if (we) im[waddr] <= wdata;
  assign rdata = im[raddr];
endmodule

// File: rtl/ifu_queued.sv
// ifu_queued: instruction fetch unit feeding a flushable fetch queue over valid/ready
module ifu_queued import ifu_queued_pkg::*; #(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int IM_AW = 10,
  parameter int FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_valid,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] redir_base,
  input  logic [25:0] redir_imm,
  input  logic [31:0] npc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign,
  output logic [31:0] fetch_pc
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] fq_pc_q [FQ_DEPTH];
  logic [31:0] fq_inst_q [FQ_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, target, pc_inc, im_data;
  logic misalign_q, misalign_d, push, pop;
  ifu_im #(.IM_AW(IM_AW)) im (
    .clk(clk),
    .we(1'b0),
    .waddr('0),
    .wdata('0),
    .raddr(fetch_pc_q[IM_AW+1:2]),
    .rdata(im_data)
  );
  assign inst_valid = count_q != '0;
  assign inst = inst_valid ? fq_inst_q[rd_q] : '0;
  assign inst_pc = inst_valid ? fq_pc_q[rd_q] : '0;
  assign misalign = misalign_q;
  assign fetch_pc = fetch_pc_q;
  // handshake, redirect target and next queue/fetch state; a redirect flushes and blocks the push
  always_comb begin
    pc_inc = fetch_pc_q + 32'd4;
    pop = inst_valid && inst_ready;
    push = !redir_valid && (count_q != CW'(FQ_DEPTH) || pop);
    target = npc_sel == IFU_SEL_RELATIVE ? redir_base + 32'd4 + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00}
           : npc_sel == IFU_SEL_IRRELATIVE ? {redir_base[31:28], redir_imm, 2'b00}
           : npc_sel == IFU_SEL_REGISTER ? {npc[31:2], 2'b00} : pc_inc;
    rd_d = redir_valid ? '0 : rd_q + PW'(pop);
    wr_d = redir_valid ? '0 : wr_q + PW'(push);
    count_d = redir_valid ? '0 : count_q + CW'(push) - CW'(pop);
    fetch_pc_d = redir_valid ? target : push ? pc_inc : fetch_pc_q;
    misalign_d = redir_valid && npc_sel == IFU_SEL_REGISTER && npc[1:0] != 2'b00;
  end
  // control state registers
  always_ff @(posedge clk)
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  // queue storage; outputs are masked while empty so stale slots never show
  always_ff @(posedge clk)
    if (push) begin
      fq_pc_q[wr_q] <= fetch_pc_q;
      fq_inst_q[wr_q] <= im_data;
    end
endmodule

// File: tb/tb_ifu_queued.sv
// tb_ifu_queued: scoreboard bench for the queued fetch unit
module tb_ifu_queued;
  logic clk = 1'b0, reset = 1'b1, redir_valid = 1'b0, inst_ready = 1'b1;
  logic [1:0] npc_sel = 2'd0;
  logic [31:0] redir_base = '0, npc = '0;
  logic [25:0] redir_imm = '0;
  logic inst_valid, misalign;
  logic [31:0] inst, inst_pc, fetch_pc, m_pc;
  int vecs = 0, errs = 0;
  logic [31:0] sb [$];
  ifu_queued dut (
    .clk(clk), .reset(reset), .redir_valid(redir_valid), .npc_sel(npc_sel),
    .redir_base(redir_base), .redir_imm(redir_imm), .npc(npc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .misalign(misalign), .fetch_pc(fetch_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] pc);
    return 32'hA000_0000 + 32'(pc[11:2]);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  initial for (int i = 0; i < 1024; i++) dut.im.im[i] = 32'hA000_0000 + i;
  always @(negedge clk)
    if (!reset && inst_valid && inst_ready && sb.size() != 0) begin
      m_pc = sb.pop_front();
      check("sb_pc", inst_pc, m_pc);
      check("sb_inst", inst, word(m_pc));
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_from(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) sb.push_back(pc + 32'(4 * i));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    redir_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    check("drain", 32'(sb.size()), 32'd0);
  endtask
  task automatic redir(input logic [1:0] sel, input logic [31:0] base, input logic [25:0] imm, input logic [31:0] n);
    redir_valid = 1'b1;
    npc_sel = sel;
    redir_base = base;
    redir_imm = imm;
    npc = n;
    tick();
  endtask
  task automatic after_redir(input logic [31:0] tgt, input logic mis, input int n);
    redir_valid = 1'b0;
    sb.delete();
    expect_from(tgt, n);
    check("bubble", {31'd0, inst_valid}, 32'd0);
    check("redir_fetch_pc", fetch_pc, tgt);
    check("misalign", {31'd0, misalign}, {31'd0, mis});
    tick();
    check("redir_valid", {31'd0, inst_valid}, 32'd1);
    check("redir_pc", inst_pc, tgt);
    check("misalign_end", {31'd0, misalign}, 32'd0);
    drain();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    do_reset();
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h3000);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    expect_from(32'h3000, 4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stream_valid", {31'd0, inst_valid}, 32'd1);
      check("stream_pc", inst_pc, 32'h3000 + 32'(4 * k));
    end
    drain();
    inst_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    check("full_count", 32'(dut.count_q), 32'd4);
    check("full_fetch_pc", fetch_pc, 32'h3010);
    expect_from(32'h3000, 5);
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("nogap_valid", {31'd0, inst_valid}, 32'd1);
      check("nogap_pc", inst_pc, 32'h3000 + 32'(4 * k));
      tick();
    end
    drain();
    redir(2'd2, 32'h3004, 26'h0C02, 32'd0);
    after_redir(32'h3008, 1'b0, 2);
    redir(2'd1, 32'h3010, 26'h000FFFC, 32'd0);
    after_redir(32'h3004, 1'b0, 3);
    redir(2'd1, 32'h3010, 26'h0000002, 32'd0);
    after_redir(32'h301c, 1'b0, 3);
    redir(2'd3, 32'd0, 26'd0, 32'h48d2);
    after_redir(32'h48d0, 1'b1, 3);
    redir(2'd3, 32'd0, 26'd0, 32'h48d0);
    after_redir(32'h48d0, 1'b0, 3);
    redir(2'd2, 32'h0000_0000, 26'h0000400, 32'd0);
    after_redir(32'h1000, 1'b0, 2);
    redir(2'd3, 32'd0, 26'd0, 32'hFFFF_FFFC);
    after_redir(32'hFFFF_FFFC, 1'b0, 3);
    redir(2'd2, 32'h3004, 26'h0C02, 32'd0);
    redir(2'd3, 32'd0, 26'd0, 32'h48d3);
    after_redir(32'h48d0, 1'b1, 4);
    inst_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    sb.push_back(32'h3000);
    inst_ready = 1'b1;
    redir(2'd0, 32'h9999_0000, 26'h3FFFFFF, 32'h1234_5677);
    check("popped_head", 32'(sb.size()), 32'd0);
    after_redir(32'h3014, 1'b0, 4);
    tick();
    do_reset();
    check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_rst_fetch_pc", fetch_pc, 32'h3000);
    expect_from(32'h3000, 2);
    tick();
    check("mid_rst_pc", inst_pc, 32'h3000);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
